pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Hazard and stall controller for the 5-stage MIPS pipeline. Drives hold/clear controls for the PC register, the fetch-issue pipeline register and the issue-execute register. Sources of stalls and flushes:
- load-use hazards
- multi-cycle mult/div occupancy
- instruction-memory wait states
- branch mispredict flushes

Also keeps saturating stall and flush counters for performance debug.

Parameters:
MD_LATENCY, 32, cycles the HI/LO unit stays busy after ex_md_start_i
MD_CNT_W, 6, width of mult/div busy counter; must hold MD_LATENCY
CNT_W, 16, width of performance counters

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
id_valid_i  input  1  issue stage holds a valid instruction
id_rs_i  input  5  issue-stage rs field
id_rt_i  input  5  issue-stage rt field
id_uses_rt_i  input  1  issue instruction reads rt as a source
id_is_mfhilo_i  input  1  issue instruction is MFHI/MFLO
id_is_md_i  input  1  issue instruction is MULT/MULTU/DIV/DIVU
ex_mem_read_i  input  1  EX-stage instruction is a load
ex_rt_i  input  5  EX-stage load destination
ex_md_start_i  input  1  mult/div entering execution this cycle
ex_brn_mispred_i  input  1  branch resolved in EX was mispredicted
imem_ready_i  input  1  instruction memory returns valid data this cycle
pc_hold_o  output  1  1 = PC register holds
iss_hold_o  output  1  to fetch-issue register enable (active-low enable: 1 = hold)
iss_clr_o  output  1  synchronous clear of fetch-issue register (bubble)
ex_clr_o  output  1  synchronous clear of issue-execute register (bubble)
md_busy_o  output  1  HI/LO unit busy
stall_cnt_o  output  CNT_W  cycles stalled by issue hazards, saturating
flush_cnt_o  output  CNT_W  mispredict flushes, saturating

Behaviour:
- Control outputs are combinational from inputs and state, with zero-cycle latency. They act on the edge that ends the current cycle.
- While reset is high, all outputs are 0, md_cnt=0 and both counters are 0.
- load_use = id_valid_i & ex_mem_read_i & (ex_rt_i!=0) & ((ex_rt_i==id_rs_i) | (id_uses_rt_i & ex_rt_i==id_rt_i)).
- md_busy_o = (md_cnt!=0).
- md_stall = id_valid_i & (id_is_mfhilo_i | id_is_md_i) & (md_busy_o | ex_md_start_i).
- id_stall = load_use | md_stall.
- md_cnt register:
  - ex_md_start_i loads MD_LATENCY. A start while already busy reloads the counter; this is legal but normally prevented by md_stall.
  - Otherwise md_cnt decrements when nonzero and holds at 0.
  - The counter is unaffected by mispredict flushes, because a mult/div in EX is older than the flushed instructions.
- Output priority, highest first:
  1. ex_brn_mispred_i: pc_hold=0, iss_hold=0, iss_clr=1, ex_clr=1. All stalls are ignored this cycle.
  2. id_stall: pc_hold=1, iss_hold=1, iss_clr=0, ex_clr=1 (bubble into EX). This applies regardless of imem_ready_i.
  3. ~imem_ready_i: pc_hold=1, iss_hold=0, iss_clr=1, ex_clr=0 (fetch bubble into issue).
  4. Otherwise all controls are 0.
- iss_hold_o and iss_clr_o are never both 1.
- Load-use stall lasts exactly 1 cycle: the load advances to MEM and load_use deasserts.
- md_stall persists until md_cnt reaches 0 and no ex_md_start_i is present. The issuing MFHI is released in the cycle md_cnt==0.
- stall_cnt_o increments on every cycle with id_stall=1 and ex_brn_mispred_i=0, saturating at all-ones.
- flush_cnt_o increments on every cycle with ex_brn_mispred_i=1, saturating at all-ones.
- Asynchronous reset mid-stall immediately drops all holds; md_cnt is cleared, so any pending busy period is abandoned.
- Register 0 never causes a load-use hazard.

Test Plan:
- Load with ex_rt=5 in EX, issue reads rs=5 → one cycle of pc_hold=1, iss_hold=1, ex_clr=1, then controls 0; stall_cnt_o=1.
- Load with ex_rt=0 and rs=0, or rt=5 with id_uses_rt_i=0 → no stall; all controls 0.
- ex_md_start_i pulse with MD_LATENCY=32, MFHI in issue next cycle → md_busy_o high 32 cycles; stall 32 cycles; MFHI released when md_cnt hits 0; stall_cnt_o=32 at that point.
- ex_brn_mispred_i coincident with load_use and imem_ready_i=0 → iss_clr=1, ex_clr=1, holds=0; flush_cnt_o +1; stall_cnt_o unchanged.
- imem_ready_i low 3 cycles with no hazard → pc_hold=1 and iss_clr=1 for 3 cycles; with concurrent load_use that cycle shows iss_hold=1, iss_clr=0, ex_clr=1.
- Reset asserted mid md busy (md_cnt=10) → outputs 0 immediately; after release md_busy_o=0 and counters read 0. Separately, drive 65540 mispredict cycles → flush_cnt_o saturates at 0xFFFF.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use, mult/div, imem-wait and mispredict stall/flush control with perf counters
module pipe_hazard_ctrl #(
  parameter int MD_LATENCY = 32,
  parameter int MD_CNT_W = 6,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic             id_is_mfhilo_i,
  input  logic             id_is_md_i,
  input  logic             ex_mem_read_i,
  input  logic [4:0]       ex_rt_i,
  input  logic             ex_md_start_i,
  input  logic             ex_brn_mispred_i,
  input  logic             imem_ready_i,
  output logic             pc_hold_o,
  output logic             iss_hold_o,
  output logic             iss_clr_o,
  output logic             ex_clr_o,
  output logic             md_busy_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);
  logic [MD_CNT_W-1:0] md_cnt;
  logic load_use, md_stall, id_stall;
  always_comb begin
    load_use = id_valid_i & ex_mem_read_i & (ex_rt_i != 5'd0) &
               ((ex_rt_i == id_rs_i) | (id_uses_rt_i & (ex_rt_i == id_rt_i)));
    md_busy_o = md_cnt != '0;
    md_stall = id_valid_i & (id_is_mfhilo_i | id_is_md_i) & (md_busy_o | ex_md_start_i);
    id_stall = load_use | md_stall;
    // reset gates the combinational controls so holds drop the instant reset rises
    pc_hold_o = ~reset & ~ex_brn_mispred_i & (id_stall | ~imem_ready_i);
    iss_hold_o = ~reset & ~ex_brn_mispred_i & id_stall;
    iss_clr_o = ~reset & (ex_brn_mispred_i | (~id_stall & ~imem_ready_i));
    ex_clr_o = ~reset & (ex_brn_mispred_i | id_stall);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_cnt <= '0;
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      md_cnt <= ex_md_start_i ? MD_CNT_W'(MD_LATENCY) : (md_busy_o ? md_cnt - MD_CNT_W'(1) : md_cnt);
      if (id_stall & ~ex_brn_mispred_i & ~&stall_cnt_o) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      if (ex_brn_mispred_i & ~&flush_cnt_o) flush_cnt_o <= flush_cnt_o + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and random checks of pipe_hazard_ctrl against a rule-level model
module tb_pipe_hazard_ctrl;
  localparam int LAT = 32;
  localparam int CMAX = 65535;
  logic clk = 0, reset = 1;
  logic id_valid, id_uses_rt, id_is_mfhilo, id_is_md, ex_mem_read, ex_md_start, ex_brn_mispred, imem_ready;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic pc_hold, iss_hold, iss_clr, ex_clr, md_busy;
  logic [15:0] stall_cnt, flush_cnt;
  int checks = 0, failures = 0;
  int md_rem = 0, sc = 0, fc = 0;

  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .id_uses_rt_i(id_uses_rt), .id_is_mfhilo_i(id_is_mfhilo), .id_is_md_i(id_is_md),
    .ex_mem_read_i(ex_mem_read), .ex_rt_i(ex_rt), .ex_md_start_i(ex_md_start),
    .ex_brn_mispred_i(ex_brn_mispred), .imem_ready_i(imem_ready), .pc_hold_o(pc_hold),
    .iss_hold_o(iss_hold), .iss_clr_o(iss_clr), .ex_clr_o(ex_clr), .md_busy_o(md_busy),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0; id_is_mfhilo = 0; id_is_md = 0;
    ex_mem_read = 0; ex_rt = 0; ex_md_start = 0; ex_brn_mispred = 0; imem_ready = 1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pc_hold"}, 32'(pc_hold), 0);
    check({tag, "_iss_hold"}, 32'(iss_hold), 0);
    check({tag, "_iss_clr"}, 32'(iss_clr), 0);
    check({tag, "_ex_clr"}, 32'(ex_clr), 0);
    check({tag, "_md_busy"}, 32'(md_busy), 0);
    check({tag, "_stall_cnt"}, 32'(stall_cnt), 0);
    check({tag, "_flush_cnt"}, 32'(flush_cnt), 0);
  endtask

  // called right after a negedge with inputs driven; checks this cycle then advances one clock
  task automatic step();
    bit lu, mds, ids, mis;
    lu = id_valid && ex_mem_read && ex_rt != 0 &&
         (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
    mds = id_valid && (id_is_mfhilo || id_is_md) && (md_rem > 0 || ex_md_start);
    ids = lu || mds;
    mis = ex_brn_mispred;
    #1;
    check("pc_hold", 32'(pc_hold), 32'(!mis && (ids || !imem_ready)));
    check("iss_hold", 32'(iss_hold), 32'(!mis && ids));
    check("iss_clr", 32'(iss_clr), 32'(mis || (!ids && !imem_ready)));
    check("ex_clr", 32'(ex_clr), 32'(mis || ids));
    check("hold_clr_excl", 32'(iss_hold & iss_clr), 0);
    check("md_busy", 32'(md_busy), 32'(md_rem > 0));
    check("stall_cnt", 32'(stall_cnt), 32'(sc));
    check("flush_cnt", 32'(flush_cnt), 32'(fc));
    @(posedge clk);
    md_rem = ex_md_start ? LAT : (md_rem > 0 ? md_rem - 1 : 0);
    if (ids && !mis && sc < CMAX) sc++;
    if (mis && fc < CMAX) fc++;
    @(negedge clk);
  endtask

  initial begin
    idle();
    @(negedge clk); @(negedge clk);
    #1 check_zero("reset");
    @(negedge clk);
    reset = 0;
    // load-use on rs, then the load moves on
    id_valid = 1; id_rs = 5; ex_mem_read = 1; ex_rt = 5;
    step();
    ex_mem_read = 0;
    step();
    check("lu_stall_cnt_one", 32'(stall_cnt), 1);
    // no hazard: r0 destination, and rt match without rt use
    ex_mem_read = 1; ex_rt = 0; id_rs = 0;
    step();
    ex_rt = 5; id_rs = 3; id_rt = 5; id_uses_rt = 0;
    step();
    idle();
    // mult/div busy then MFHI in issue
    ex_md_start = 1;
    step();
    ex_md_start = 0; id_valid = 1; id_is_mfhilo = 1;
    repeat (LAT + 1) step();
    check("md_stall_total", 32'(stall_cnt), 33);
    // mispredict overrides load-use and imem wait
    idle();
    id_valid = 1; id_rs = 7; ex_mem_read = 1; ex_rt = 7; imem_ready = 0; ex_brn_mispred = 1;
    step();
    check("mis_flush_cnt", 32'(flush_cnt), 1);
    check("mis_stall_unchanged", 32'(stall_cnt), 33);
    // imem wait 3 cycles, then with load-use
    idle(); imem_ready = 0;
    repeat (3) step();
    id_valid = 1; id_rs = 9; ex_mem_read = 1; ex_rt = 9;
    step();
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      id_valid = ($urandom_range(0, 3) != 0);
      id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3));
      id_uses_rt = 1'($urandom);
      id_is_mfhilo = ($urandom_range(0, 7) == 0);
      id_is_md = ($urandom_range(0, 7) == 0);
      ex_mem_read = 1'($urandom);
      ex_rt = 5'($urandom_range(0, 3));
      ex_md_start = ($urandom_range(0, 39) == 0);
      ex_brn_mispred = ($urandom_range(0, 9) == 0);
      imem_ready = ($urandom_range(0, 4) != 0);
      step();
    end
    // async reset in the middle of a busy period
    idle(); ex_md_start = 1;
    step();
    ex_md_start = 0;
    repeat (22) step();
    id_valid = 1; id_is_mfhilo = 1;
    #2 check("pre_reset_busy", 32'(md_busy), 1);
    check("pre_reset_hold", 32'(pc_hold), 1);
    reset = 1;
    #1 check_zero("async_reset");
    md_rem = 0; sc = 0; fc = 0;
    idle();
    @(negedge clk); @(negedge clk);
    reset = 0;
    step();
    // flush counter saturation
    ex_brn_mispred = 1;
    repeat (65540) step();
    check("flush_sat", 32'(flush_cnt), 32'hFFFF);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
